// File: rtl/execute_mc.sv
// rtl/execute_mc.sv - execute stage: single-cycle ALU plus iterative multiply/divide
// Results are held in an output register with a valid/ready handshake.
module execute_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data_ex_mem,
  input  logic [WIDTH-1:0] data_mem_wb,
  input  logic [WIDTH-1:0] line_data,
  input  logic [WIDTH-1:0] imm_in,
  input  logic [1:0]       fwdA,
  input  logic [1:0]       fwdB,
  input  logic             isI,
  input  logic [3:0]       alu_op,
  input  logic [1:0]       mdu_op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             op_rem;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b_fwd;
  logic [WIDTH-1:0] op_b;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic             accept;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !rst;
  assign accept   = in_valid && in_ready && !flush;
  assign busy     = (state != IDLE);

  always_comb begin
    op_a = data_mem_wb;
    case (fwdA)
      2'd0: op_a = data_mem_wb;
      2'd1: op_a = data_ex_mem;
      2'd2: op_a = data1;
      2'd3: op_a = line_data;
      default: op_a = data_mem_wb;
    endcase
    op_b_fwd = data_mem_wb;
    case (fwdB)
      2'd0: op_b_fwd = data_mem_wb;
      2'd1: op_b_fwd = data_ex_mem;
      2'd2: op_b_fwd = data2;
      2'd3: op_b_fwd = line_data;
      default: op_b_fwd = data_mem_wb;
    endcase
    op_b  = isI ? imm_in : op_b_fwd;
    shamt = op_b[SW-1:0];
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0: alu_res = op_a + op_b;
      4'd1: alu_res = op_a - op_b;
      4'd2: alu_res = op_a & op_b;
      4'd3: alu_res = op_a | op_b;
      4'd4: alu_res = op_a ^ op_b;
      4'd5: alu_res = op_a << shamt;
      4'd6: alu_res = op_a >> shamt;
      4'd7: alu_res = $signed(op_a) >>> shamt;
      4'd8: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  // Restoring division: acc is the partial remainder, opa shifts the dividend out and quotient in.
  always_comb begin
    div_shift = {acc, opa[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    div_ge    = (div_shift >= {1'b0, opb});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      opa         <= '0;
      opb         <= '0;
      op_rem      <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            acc <= '0;
            opa <= op_a;
            opb <= op_b;
            op_rem <= mdu_op[0];
            div_by_zero <= 1'b0;
            if (mdu_op == 2'd0) begin
              result    <= alu_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (mdu_op == 2'd1) begin
              state <= MUL;
            end else if (op_b == '0) begin
              result      <= (mdu_op == 2'd2) ? '1 : op_a;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              state <= DIV;
            end
          end
        end
        MUL: begin
          if (cnt == CW'(WIDTH)) begin
            result    <= acc;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            if (opb[0])
              acc <= acc + opa;
            opa <= opa << 1;
            opb <= opb >> 1;
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (cnt == CW'(WIDTH)) begin
            result    <= op_rem ? acc : opa;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            acc <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            opa <= {opa[WIDTH-2:0], div_ge};
            cnt <= cnt + 1'b1;
          end
        end
        // The result register keeps out_valid after leaving DONE, so a new op may be accepted on the handshake edge.
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_mc.sv
// tb/tb_execute_mc.sv - directed self-checking bench for execute_mc
module tb_execute_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data1, data2, data_ex_mem, data_mem_wb, line_data, imm_in;
  logic [1:0]   fwdA, fwdB;
  logic         isI;
  logic [3:0]   alu_op;
  logic [1:0]   mdu_op;
  logic         in_valid, in_ready, flush, out_valid, out_ready;
  logic [W-1:0] result;
  logic         div_by_zero, busy;

  int n_cmp = 0;
  int n_fail = 0;

  execute_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .data1(data1), .data2(data2),
    .data_ex_mem(data_ex_mem), .data_mem_wb(data_mem_wb), .line_data(line_data),
    .imm_in(imm_in), .fwdA(fwdA), .fwdB(fwdB), .isI(isI), .alu_op(alu_op),
    .mdu_op(mdu_op), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] mdu, input logic [3:0] alu,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    fwdA = 2'd2; fwdB = 2'd2; isI = 1'b0;
    data1 = a; data2 = b; mdu_op = mdu; alu_op = alu;
  endtask

  task automatic issue();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data1 = '0; data2 = '0; data_ex_mem = '0; data_mem_wb = '0; line_data = '0; imm_in = '0;
    fwdA = 2'd0; fwdB = 2'd0; isI = 1'b0; alu_op = 4'd0; mdu_op = 2'd0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got v=%b b=%b z=%b want 0 0 0", out_valid, busy, div_by_zero); end
    n_cmp++; if (result !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_alu();
    set_op(2'd0, 4'd0, 32'd5, 32'd7); issue();
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'd12) begin
      n_fail++; $display("FAIL add got v=%b r=%h want 1 0000000c", out_valid, result); end
    drain();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got %b want 0", out_valid); end
    set_op(2'd0, 4'd1, 32'd5, 32'd7); issue();
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL sub got v=%b r=%h want 1 fffffffe", out_valid, result); end
    drain();
    fwdA = 2'd0; fwdB = 2'd1; data_mem_wb = 32'd100; data_ex_mem = 32'd23; alu_op = 4'd0; mdu_op = 2'd0;
    issue();
    n_cmp++; if (result !== 32'd123) begin n_fail++; $display("FAIL fwd_add got %h want 0000007b", result); end
    drain();
    fwdA = 2'd1; fwdB = 2'd0; data_ex_mem = 32'hF0F0_1234; data_mem_wb = 32'h0FF0_00FF; alu_op = 4'd4;
    issue();
    n_cmp++; if (result !== 32'hFF00_12CB) begin n_fail++; $display("FAIL xor got %h want ff0012cb", result); end
    drain();
    set_op(2'd0, 4'd5, 32'h0000_0003, 32'h0000_0025); issue();
    n_cmp++; if (result !== 32'h0000_0060) begin n_fail++; $display("FAIL sll got %h want 00000060", result); end
    drain();
    set_op(2'd0, 4'd12, 32'd9, 32'd9); issue();
    n_cmp++; if (result !== 32'd0) begin n_fail++; $display("FAIL bad_op got %h want 0", result); end
    drain();
  endtask

  task automatic test_shift_slt();
    fwdA = 2'd3; line_data = 32'h8000_0000; isI = 1'b1; imm_in = 32'd4; mdu_op = 2'd0; alu_op = 4'd7;
    issue();
    n_cmp++; if (result !== 32'hF800_0000) begin n_fail++; $display("FAIL sra got %h want f8000000", result); end
    drain();
    alu_op = 4'd8; issue();
    n_cmp++; if (result !== 32'd1) begin n_fail++; $display("FAIL slt got %h want 00000001", result); end
    drain();
    alu_op = 4'd6; issue();
    n_cmp++; if (result !== 32'h0800_0000) begin n_fail++; $display("FAIL srl got %h want 08000000", result); end
    drain();
  endtask

  task automatic test_mul();
    int lat;
    set_op(2'd1, 4'd0, 32'h0000_FFFF, 32'h0001_0001); issue();
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mul_start got b=%b v=%b r=%b want 1 0 0", busy, out_valid, in_ready); end
    // A request presented while busy must be ignored.
    set_op(2'd0, 4'd0, 32'd1, 32'd1); in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    wait_out(lat);
    n_cmp++; if (lat + 3 !== W + 1) begin n_fail++; $display("FAIL mul_latency got %0d want %0d", lat + 3, W + 1); end
    n_cmp++; if (result !== 32'hFFFF_FFFF || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL mul_result got %h z=%b want ffffffff 0", result, div_by_zero); end
    drain();
    set_op(2'd1, 4'd0, 32'h1234_5678, 32'd3); issue();
    wait_out(lat);
    n_cmp++; if (lat !== W + 1 || result !== 32'h369D_0368) begin
      n_fail++; $display("FAIL mul2 got lat=%0d r=%h want %0d 369d0368", lat, result, W + 1); end
    drain();
  endtask

  task automatic test_div();
    int lat;
    set_op(2'd2, 4'd0, 32'd100, 32'd7); issue();
    wait_out(lat);
    n_cmp++; if (lat !== W + 1 || result !== 32'd14 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL divu got lat=%0d r=%h z=%b want %0d 0000000e 0", lat, result, div_by_zero, W + 1); end
    drain();
    set_op(2'd3, 4'd0, 32'd100, 32'd7); issue();
    wait_out(lat);
    n_cmp++; if (lat !== W + 1 || result !== 32'd2) begin
      n_fail++; $display("FAIL remu got lat=%0d r=%h want %0d 00000002", lat, result, W + 1); end
    drain();
    set_op(2'd2, 4'd0, 32'hFFFF_FFFF, 32'h0000_0010); issue();
    wait_out(lat);
    n_cmp++; if (result !== 32'h0FFF_FFFF) begin n_fail++; $display("FAIL divu_big got %h want 0fffffff", result); end
    drain();
    set_op(2'd2, 4'd0, 32'd9, 32'd0); issue();
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFF || div_by_zero !== 1'b1) begin
      n_fail++; $display("FAIL divu_zero got v=%b r=%h z=%b want 1 ffffffff 1", out_valid, result, div_by_zero); end
    drain();
    set_op(2'd3, 4'd0, 32'd9, 32'd0); issue();
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'd9 || div_by_zero !== 1'b1) begin
      n_fail++; $display("FAIL remu_zero got v=%b r=%h z=%b want 1 00000009 1", out_valid, result, div_by_zero); end
    drain();
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    set_op(2'd0, 4'd0, 32'd3, 32'd4); issue();
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) bad++;
      tick();
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b want 1", in_ready); end
    set_op(2'd0, 4'd0, 32'd10, 32'd20); issue();
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'd30) begin
      n_fail++; $display("FAIL b2b got v=%b r=%h want 1 0000001e", out_valid, result); end
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    int seen = 0;
    set_op(2'd1, 4'd0, 32'h0000_FFFF, 32'h0001_0001); issue();
    repeat (10) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_mul got v=%b b=%b r=%b want 0 0 1", out_valid, busy, in_ready); end
    repeat (40) begin tick(); if (out_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_result got %0d want 0", seen); end
    set_op(2'd0, 4'd0, 32'd1, 32'd2); in_valid = 1'b1; flush = 1'b1;
    tick(); in_valid = 1'b0; flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_wins got v=%b b=%b want 0 0", out_valid, busy); end
    set_op(2'd2, 4'd0, 32'd5, 32'd0); issue();
    flush = 1'b1; tick(); flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL flush_held got v=%b z=%b want 0 0", out_valid, div_by_zero); end
  endtask

  task automatic test_rst_abort();
    int seen = 0;
    set_op(2'd1, 4'd0, 32'h0000_FFFF, 32'h0001_0001); issue();
    repeat (10) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      n_fail++; $display("FAIL rst_mul got v=%b b=%b r=%h want 0 0 0", out_valid, busy, result); end
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mul_ready got %b want 1", in_ready); end
    repeat (40) begin tick(); if (out_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rst_no_result got %0d want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_shift_slt();
    test_mul();
    test_div();
    test_back_to_back();
    test_flush();
    test_rst_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
